button_event_arbiter: RTL and testbench
=======================================

Name: button_event_arbiter

Overview:
- Controller between per-button Debouncer outputs and the BCD counter datapath.
- Arbitrates N debounced button levels and owns one button at a time.
- Converts the owned press into a one-cycle event carrying the button index, with optional hold-to-auto-repeat.
- Downstream counter logic consumes EventValid/EventId as increment/decrement/clear commands.

Parameters:
- NumButtons, 4, number of debounced button inputs (>=2).
- IdWidth, 2, width of EventId; must satisfy 2^IdWidth >= NumButtons.
- TimerWidth, 8, width of the hold/repeat timer.
- HoldDelay, 50, cycles from press event to first repeat event (2..2^TimerWidth).
- RepeatPeriod, 10, cycles between repeat events (1..2^TimerWidth).

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- ButtonIn  in  NumButtons  debounced button levels, 1 = pressed.
- Enable  in  1  arbiter enable; when 0, new presses are ignored.
- EventValid  out  1  one-cycle event strobe.
- EventId  out  IdWidth  index of the event's button; valid only while EventValid=1.
- EventRepeat  out  1  0 = initial press event, 1 = auto-repeat event; valid with EventValid.
- Busy  out  1  high while a button is owned (HOLD or REPEAT).

Behaviour:
- Reset (Reset=0) forces, asynchronously:
  - state IDLE, Timer=0;
  - ButtonPrev = all ones, so a button held through reset never fires and must be released and re-pressed;
  - EventValid=0, EventId=0, EventRepeat=0, Busy=0.
- Rise = ButtonIn & ~ButtonPrev; ButtonPrev <= ButtonIn every edge.
- All outputs are registered. EventValid is high for exactly one cycle per event and never on consecutive cycles unless RepeatPeriod=1.
- FSM states:
  - IDLE: if Enable=1 and Rise!=0 at edge k:
    - Owner = lowest set index of Rise.
    - From edge k: EventValid=1, EventId=Owner, EventRepeat=0.
    - Timer=0; next state HOLD.
    - Other simultaneous rises are dropped, not queued.
  - HOLD: exits to IDLE with no event if ButtonIn[Owner]=0 or Enable=0. Otherwise Timer increments; when Timer==HoldDelay-1:
    - emit event with EventRepeat=1, i.e. at edge k+HoldDelay;
    - Timer=0; next state REPEAT.
  - REPEAT: same exit rule as HOLD. When Timer==RepeatPeriod-1, emit a repeat event and set Timer=0. Repeats occur at k+HoldDelay+n*RepeatPeriod.
- Busy=1 exactly in HOLD and REPEAT.
- Rises on non-owner buttons while Busy are discarded.
- After the owner releases, a still-held other button does not fire; it needs a new rise.
- Release or Enable=0 in the same cycle as timer expiry: release/disable wins, no event.
- Owner release and a new rise on another button at the same edge: return to IDLE; that rise is lost.
- Enable toggling while in IDLE does not generate events from already-held buttons.
- Timer never wraps: parameter bounds guarantee expiry before overflow.

Optional Feature:
- Macro: BUTTON_AUTOREPEAT_EN.
- Defined: HOLD/REPEAT behaviour as above.
- Undefined:
  - No timer logic.
  - After a press event the FSM enters HOLD and waits only for owner release or Enable=0.
  - EventRepeat is tied to 0.
  - HoldDelay and RepeatPeriod are unused.

Decomposition:
- Shared package (button_pkg):
  - state encoding localparams: ST_IDLE=0, ST_HOLD=1, ST_REPEAT=2 (2-bit);
  - the IdWidth-from-NumButtons sizing constant.
- One natural combinational sub-module: button_priority_encoder (NumButtons-bit vector in; Valid plus lowest-set index out). It is reused by the counter top for other multi-source selects.

Test Plan:
All scenarios use NumButtons=4, HoldDelay=4, RepeatPeriod=2, TimerWidth=3; k is the first edge sampling the rise.
1. Hold ButtonIn=0010 through reset release -> no EventValid. Release, then re-press at k -> EventValid=1, EventId=1, EventRepeat=0 at k only.
2. ButtonIn[2] pressed at k, released before k+3 -> exactly one event (Id=2, Repeat=0). Busy high k..release+1, then 0.
3. ButtonIn[1] held 10 cycles from k -> events at k (Repeat=0) and at k+4, k+6, k+8 (Repeat=1). None after release.
4. ButtonIn 0000->0101 at k -> single event Id=0. Release bit0 with bit2 still held -> no event. Re-press bit2 -> event Id=2.
5. Enable=0 during a rise -> no event, Busy=0. Then Enable=0 at k+5 during REPEAT -> no event at k+6, Busy=0 from k+6.
6. Assert Reset mid-REPEAT between edges -> EventValid, Busy, EventRepeat drop to 0 immediately, without waiting for Clk.

Source files
------------

// File: rtl/button_pkg.sv
// Shared definitions for the button-event arbiter: FSM state encoding and
// the sizing helper that derives an index width from a button count.
package button_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    typedef enum logic [1:0] {
        sIdle   = ST_IDLE,
        sHold   = ST_HOLD,
        sRepeat = ST_REPEAT
    } stateT;

    // Bits needed to index numItems sources (at least one bit).
    function automatic int idWidthFor(input int numItems);
        return (numItems <= 1) ? 1 : $clog2(numItems);
    endfunction

    localparam int DefaultNumButtons = 4;
    localparam int DefaultIdWidth    = idWidthFor(DefaultNumButtons);

endpackage

// File: rtl/button_priority_encoder.sv
// Lowest-index-wins priority encoder. Valid flags any set request; Index is
// the position of the lowest set bit (0 when nothing is requested).
module button_priority_encoder #(
    parameter int NumInputs  = 4,
    parameter int IndexWidth = 2
) (
    input  logic [NumInputs-1:0]  Request,
    output logic                  Valid,
    output logic [IndexWidth-1:0] Index
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        Valid = 1'b0;
        Index = '0;
        for (int i = NumInputs - 1; i >= 0; i--) begin
            if (Request[i]) begin
                Valid = 1'b1;
                Index = IndexWidth'(i);
            end
        end
    end

endmodule

// File: rtl/button_event_arbiter.sv
// Button event arbiter: owns one debounced button at a time and turns its
// press into a one-cycle event tagged with the button index.
// Optional hold-to-auto-repeat is enabled by defining BUTTON_AUTOREPEAT_EN;
// without it the arbiter emits only the initial press event and the timer,
// HoldDelay and RepeatPeriod have no effect.
module button_event_arbiter
    import button_pkg::*;
#(
    parameter int NumButtons   = 4,
    parameter int IdWidth      = idWidthFor(NumButtons),
    parameter int TimerWidth   = 8,
    parameter int HoldDelay    = 50,
    parameter int RepeatPeriod = 10
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [NumButtons-1:0] ButtonIn,
    input  logic                  Enable,
    output logic                  EventValid,
    output logic [IdWidth-1:0]    EventId,
    output logic                  EventRepeat,
    output logic                  Busy
);

    stateT                 state;
    logic [NumButtons-1:0] buttonPrev;
    logic [NumButtons-1:0] riseVec;
    logic [NumButtons-1:0] ownerMask;
    logic                  riseValid;
    logic [IdWidth-1:0]    riseIdx;
    logic                  stayOwned;

    assign riseVec   = ButtonIn & ~buttonPrev;
    // Ownership persists only while the owner is held and the arbiter enabled;
    // this check is evaluated before any timer expiry so release/disable wins.
    assign stayOwned = Enable & (|(ButtonIn & ownerMask));

    button_priority_encoder #(
        .NumInputs  (NumButtons),
        .IndexWidth (IdWidth)
    ) uRiseEncoder (
        .Request (riseVec),
        .Valid   (riseValid),
        .Index   (riseIdx)
    );

`ifdef BUTTON_AUTOREPEAT_EN
    logic [TimerWidth-1:0] timer;
`else
    logic unusedParams;
    assign unusedParams = ^{32'(TimerWidth), 32'(HoldDelay), 32'(RepeatPeriod)};
`endif

    // Arbitration FSM with registered event outputs; buttonPrev resets to all
    // ones so a button held through reset needs a fresh press.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state       <= sIdle;
            buttonPrev  <= '1;
            ownerMask   <= '0;
            EventValid  <= 1'b0;
            EventId     <= '0;
            EventRepeat <= 1'b0;
            Busy        <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
            timer       <= '0;
`endif
        end else begin
            buttonPrev  <= ButtonIn;
            EventValid  <= 1'b0;
            EventRepeat <= 1'b0;
            case (state)
                sIdle: begin
                    if (Enable && riseValid) begin
                        state      <= sHold;
                        ownerMask  <= {{(NumButtons-1){1'b0}}, 1'b1} << riseIdx;
                        EventValid <= 1'b1;
                        EventId    <= riseIdx;
                        Busy       <= 1'b1;
`ifdef BUTTON_AUTOREPEAT_EN
                        timer      <= '0;
`endif
                    end
                end
                sHold: begin
                    if (!stayOwned) begin
                        state <= sIdle;
                        Busy  <= 1'b0;
                    end
`ifdef BUTTON_AUTOREPEAT_EN
                    else if (timer == TimerWidth'(HoldDelay - 1)) begin
                        state       <= sRepeat;
                        timer       <= '0;
                        EventValid  <= 1'b1;
                        EventRepeat <= 1'b1;
                    end else begin
                        timer <= timer + TimerWidth'(1);
                    end
`endif
                end
`ifdef BUTTON_AUTOREPEAT_EN
                sRepeat: begin
                    if (!stayOwned) begin
                        state <= sIdle;
                        Busy  <= 1'b0;
                    end else if (timer == TimerWidth'(RepeatPeriod - 1)) begin
                        timer       <= '0;
                        EventValid  <= 1'b1;
                        EventRepeat <= 1'b1;
                    end else begin
                        timer <= timer + TimerWidth'(1);
                    end
                end
`endif
                default: begin
                    state <= sIdle;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter with NumButtons=4, HoldDelay=4,
// RepeatPeriod=2, TimerWidth=3. Repeat expectations follow BUTTON_AUTOREPEAT_EN.
module tb_button_event_arbiter;

`ifdef BUTTON_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset;
    logic [3:0] ButtonIn;
    logic       Enable;
    logic       EventValid;
    logic [1:0] EventId;
    logic       EventRepeat;
    logic       Busy;

    int compared   = 0;
    int mismatched = 0;

    button_event_arbiter #(
        .NumButtons   (4),
        .IdWidth      (2),
        .TimerWidth   (3),
        .HoldDelay    (4),
        .RepeatPeriod (2)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .ButtonIn    (ButtonIn),
        .Enable      (Enable),
        .EventValid  (EventValid),
        .EventId     (EventId),
        .EventRepeat (EventRepeat),
        .Busy        (Busy)
    );

    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Step to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic expectOut(input string tag, input logic v, input logic [1:0] id,
                             input logic rep, input logic b);
        chk({tag, ".valid"}, 32'(EventValid), 32'(v));
        if (v) begin
            chk({tag, ".id"}, 32'(EventId), 32'(id));
            chk({tag, ".repeat"}, 32'(EventRepeat), 32'(rep));
        end
        chk({tag, ".busy"}, 32'(Busy), 32'(b));
    endtask

    initial begin
        logic expV;

        // 1: button held through reset never fires; re-press does.
        Reset    = 1'b0;
        Enable   = 1'b1;
        ButtonIn = 4'b0010;
        tick();
        tick();
        chk("rst.valid",  32'(EventValid),  32'd0);
        chk("rst.id",     32'(EventId),     32'd0);
        chk("rst.repeat", 32'(EventRepeat), 32'd0);
        chk("rst.busy",   32'(Busy),        32'd0);
        Reset = 1'b1;
        tick(); expectOut("s1.held0", 1'b0, 2'd0, 1'b0, 1'b0);
        tick(); expectOut("s1.held1", 1'b0, 2'd0, 1'b0, 1'b0);
        tick(); expectOut("s1.held2", 1'b0, 2'd0, 1'b0, 1'b0);
        ButtonIn = 4'b0000;
        tick(); expectOut("s1.rel", 1'b0, 2'd0, 1'b0, 1'b0);
        ButtonIn = 4'b0010;
        tick(); expectOut("s1.k", 1'b1, 2'd1, 1'b0, 1'b1);
        tick(); expectOut("s1.k1", 1'b0, 2'd0, 1'b0, 1'b1);
        ButtonIn = 4'b0000;
        tick(); expectOut("s1.k2", 1'b0, 2'd0, 1'b0, 1'b0);

        // 2: short press on button 2, one event only.
        ButtonIn = 4'b0100;
        tick(); expectOut("s2.k", 1'b1, 2'd2, 1'b0, 1'b1);
        tick(); expectOut("s2.k1", 1'b0, 2'd0, 1'b0, 1'b1);
        tick(); expectOut("s2.k2", 1'b0, 2'd0, 1'b0, 1'b1);
        ButtonIn = 4'b0000;
        tick(); expectOut("s2.k3", 1'b0, 2'd0, 1'b0, 1'b0);
        tick(); expectOut("s2.k4", 1'b0, 2'd0, 1'b0, 1'b0);

        // 3: hold button 1 for 10 cycles; repeats at k+4, k+6, k+8; release at k+10 beats expiry.
        ButtonIn = 4'b0010;
        tick(); expectOut("s3.k", 1'b1, 2'd1, 1'b0, 1'b1);
        for (int i = 1; i <= 9; i++) begin
            tick();
            expV = AR && (i == 4 || i == 6 || i == 8);
            expectOut($sformatf("s3.k%0d", i), expV, 2'd1, 1'b1, 1'b1);
        end
        ButtonIn = 4'b0000;
        tick(); expectOut("s3.k10", 1'b0, 2'd0, 1'b0, 1'b0);
        tick(); expectOut("s3.k11", 1'b0, 2'd0, 1'b0, 1'b0);

        // 4: simultaneous rises pick lowest; remaining held button needs a new rise.
        ButtonIn = 4'b0101;
        tick(); expectOut("s4.k", 1'b1, 2'd0, 1'b0, 1'b1);
        tick(); expectOut("s4.k1", 1'b0, 2'd0, 1'b0, 1'b1);
        ButtonIn = 4'b0100;
        tick(); expectOut("s4.rel0", 1'b0, 2'd0, 1'b0, 1'b0);
        tick(); expectOut("s4.held2", 1'b0, 2'd0, 1'b0, 1'b0);
        ButtonIn = 4'b0000;
        tick(); expectOut("s4.rel2", 1'b0, 2'd0, 1'b0, 1'b0);
        ButtonIn = 4'b0100;
        tick(); expectOut("s4.repress", 1'b1, 2'd2, 1'b0, 1'b1);
        ButtonIn = 4'b0000;
        tick(); expectOut("s4.end", 1'b0, 2'd0, 1'b0, 1'b0);

        // Non-owner rise while busy is discarded.
        ButtonIn = 4'b0001;
        tick(); expectOut("nb.k", 1'b1, 2'd0, 1'b0, 1'b1);
        ButtonIn = 4'b0011;
        tick(); expectOut("nb.other", 1'b0, 2'd0, 1'b0, 1'b1);
        ButtonIn = 4'b0010;
        tick(); expectOut("nb.rel", 1'b0, 2'd0, 1'b0, 1'b0);
        tick(); expectOut("nb.after", 1'b0, 2'd0, 1'b0, 1'b0);
        ButtonIn = 4'b0000;
        tick();

        // Owner release and another rise on the same edge: rise lost.
        ButtonIn = 4'b0001;
        tick(); expectOut("sw.k", 1'b1, 2'd0, 1'b0, 1'b1);
        ButtonIn = 4'b0010;
        tick(); expectOut("sw.swap", 1'b0, 2'd0, 1'b0, 1'b0);
        tick(); expectOut("sw.after", 1'b0, 2'd0, 1'b0, 1'b0);
        ButtonIn = 4'b0000;
        tick();

        // 5: disabled rise ignored; enabling with button held gives nothing.
        Enable   = 1'b0;
        ButtonIn = 4'b1000;
        tick(); expectOut("s5.dis0", 1'b0, 2'd0, 1'b0, 1'b0);
        tick(); expectOut("s5.dis1", 1'b0, 2'd0, 1'b0, 1'b0);
        Enable = 1'b1;
        tick(); expectOut("s5.en", 1'b0, 2'd0, 1'b0, 1'b0);
        ButtonIn = 4'b0000;
        tick();
        ButtonIn = 4'b1000;
        tick(); expectOut("s5.k", 1'b1, 2'd3, 1'b0, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            expV = AR && (i == 4);
            expectOut($sformatf("s5.k%0d", i), expV, 2'd3, 1'b1, 1'b1);
        end
        Enable = 1'b0;
        tick(); expectOut("s5.k6", 1'b0, 2'd0, 1'b0, 1'b0);
        tick(); expectOut("s5.k7", 1'b0, 2'd0, 1'b0, 1'b0);
        Enable   = 1'b1;
        ButtonIn = 4'b0000;
        tick();

        // 6: asynchronous reset mid-sequence clears outputs between edges.
        ButtonIn = 4'b0010;
        tick(); expectOut("s6.k", 1'b1, 2'd1, 1'b0, 1'b1);
        tick();
        tick();
        tick();
        tick(); expectOut("s6.k4", AR, 2'd1, 1'b1, 1'b1);
        #2;
        Reset = 1'b0;
        #1;
        chk("s6.async.valid",  32'(EventValid),  32'd0);
        chk("s6.async.repeat", 32'(EventRepeat), 32'd0);
        chk("s6.async.busy",   32'(Busy),        32'd0);
        ButtonIn = 4'b0000;
        tick();
        Reset = 1'b1;
        tick(); expectOut("s6.post", 1'b0, 2'd0, 1'b0, 1'b0);
        ButtonIn = 4'b0001;
        tick(); expectOut("s6.press", 1'b1, 2'd0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
